// File: rtl/ov7670_tx_if.sv
// ov7670_tx_if: video bus driven by the OV7670 camera-side source.
//
// Signals:
//   vsync    frame sync, active high
//   href     line valid, active high
//   px_data  pixel byte (high byte of RGB565 first, then low byte)
//
// Modports:
//   master  the sensor side (drives the bus)
//   slave   the capture side (samples the bus)
interface ov7670_tx_if;
    logic       vsync;
    logic       href;
    logic [7:0] px_data;

    modport master (output vsync, output href, output px_data);
    modport slave  (input  vsync, input  href, input  px_data);
endinterface

// File: rtl/ov7670_tx.sv
// ov7670_tx: synthesizable OV7670 camera-side source (QQVGA RGB565 by default).
// Generates vsync/href/pixel bytes frame after frame while enable is high,
// and pulses frame_done on the last cycle of every frame.
//
// Ports:
//   pclk        pixel clock, rising edge
//   in_reset    asynchronous active-high reset
//   enable      request continuous frame generation (checked in IDLE and at frame end)
//   pattern     0 = solid color, 1 = colour bars (only with OV7670_TX_TESTPAT_EN)
//   color       RGB565 colour for solid mode, sampled once per frame
//   vid         video bus (vsync, href, px_data), master modport
//   frame_done  one-cycle pulse on the last cycle of each frame
//   frame_cnt   completed frame count, wraps at 255
//
// Build option:
//   OV7670_TX_TESTPAT_EN  defined: colour-bar generator built, pattern selects it.
//                         undefined: pattern ignored, every pixel is the sampled color.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | outputs low, wait for enable
// VSYNC   | vsync high for VSYNC_LINES line periods
// VBACK   | blank for V_BACK line periods
// ACTIVE  | href high, 2*H_PIX bytes of one line
// HBLANK  | href low for H_BLANK cycles between lines
// VFRONT  | blank for V_FRONT line periods, last cycle ends the frame
module ov7670_tx #(
    parameter int H_PIX       = 160,
    parameter int V_LINES     = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic          pclk,
    input  logic          in_reset,
    input  logic          enable,
    input  logic          pattern,
    input  logic [15:0]   color,
    ov7670_tx_if.master   vid,
    output logic          frame_done,
    output logic [7:0]    frame_cnt
);

    localparam int T_LINE   = 2*H_PIX + H_BLANK;
    localparam int CYC_W    = ($clog2(T_LINE) > 9) ? $clog2(T_LINE) : 9;
    localparam int LINE_TOT = V_LINES + VSYNC_LINES + V_BACK + V_FRONT;
    localparam int LINE_W   = ($clog2(LINE_TOT + 1) > 1) ? $clog2(LINE_TOT + 1) : 1;

    localparam logic [CYC_W-1:0]  CYC_LINE  = CYC_W'(T_LINE - 1);
    localparam logic [CYC_W-1:0]  CYC_ACT   = CYC_W'(2*H_PIX - 1);
    localparam logic [CYC_W-1:0]  CYC_HBL   = CYC_W'(H_BLANK - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
    localparam logic [LINE_W-1:0] LN_VSYNC  = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] LN_VBACK  = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] LN_ACT    = LINE_W'(V_LINES - 1);
    localparam logic [LINE_W-1:0] LN_VFRONT = LINE_W'(V_FRONT - 1);
    localparam logic [LINE_W-1:0] LN_ONE    = LINE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [CYC_W-1:0]  cyc, cyc_n;        // cycles left in the current line/segment
    logic [LINE_W-1:0] lines, lines_n;    // line periods left in the current state
    logic              phase, phase_n;    // byte phase of the current ACTIVE cycle
    logic              sample;            // capture color/pattern for this frame
    logic              line_start;        // next cycle is byte 0 of a line
    logic              byte_step;         // next cycle is the following byte of the line
    logic              done_n;            // next cycle is the last cycle of the frame
    logic [15:0]       col_q;
    logic [15:0]       pix_n;             // pixel shown in the next cycle

    logic              vsync_q, href_q, frame_done_q;
    logic [7:0]        px_q;
    logic [7:0]        frame_cnt_q;

    // Next-state logic: all timers are down-counters, exit on terminal count.
    always_comb begin
        state_n    = state;
        cyc_n      = cyc;
        lines_n    = lines;
        sample     = 1'b0;
        line_start = 1'b0;
        byte_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_VSYNC;
                    cyc_n   = CYC_LINE;
                    lines_n = LN_VSYNC;
                end
            end
            ST_VSYNC: begin
                if (cyc != '0) begin
                    cyc_n = cyc - CYC_ONE;
                end else if (lines != '0) begin
                    cyc_n   = CYC_LINE;
                    lines_n = lines - LN_ONE;
                end else begin
                    state_n = ST_VBACK;
                    cyc_n   = CYC_LINE;
                    lines_n = LN_VBACK;
                    sample  = 1'b1;
                end
            end
            ST_VBACK: begin
                if (cyc != '0) begin
                    cyc_n = cyc - CYC_ONE;
                end else if (lines != '0) begin
                    cyc_n   = CYC_LINE;
                    lines_n = lines - LN_ONE;
                end else begin
                    state_n    = ST_ACTIVE;
                    cyc_n      = CYC_ACT;
                    lines_n    = LN_ACT;
                    line_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cyc != '0) begin
                    cyc_n     = cyc - CYC_ONE;
                    byte_step = 1'b1;
                end else begin
                    state_n = ST_HBLANK;
                    cyc_n   = CYC_HBL;
                end
            end
            ST_HBLANK: begin
                if (cyc != '0) begin
                    cyc_n = cyc - CYC_ONE;
                end else if (lines != '0) begin
                    state_n    = ST_ACTIVE;
                    cyc_n      = CYC_ACT;
                    lines_n    = lines - LN_ONE;
                    line_start = 1'b1;
                end else begin
                    state_n = ST_VFRONT;
                    cyc_n   = CYC_LINE;
                    lines_n = LN_VFRONT;
                end
            end
            ST_VFRONT: begin
                if (cyc != '0) begin
                    cyc_n = cyc - CYC_ONE;
                end else if (lines != '0) begin
                    cyc_n   = CYC_LINE;
                    lines_n = lines - LN_ONE;
                end else if (enable) begin
                    state_n = ST_VSYNC;
                    cyc_n   = CYC_LINE;
                    lines_n = LN_VSYNC;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        phase_n = phase;
        if (line_start) begin
            phase_n = 1'b0;
        end else if (byte_step) begin
            phase_n = ~phase;
        end
    end

    // Outputs are registered from the next-cycle view so they line up with the state.
    assign done_n = (state_n == ST_VFRONT) && (cyc_n == '0) && (lines_n == '0);

`ifdef OV7670_TX_TESTPAT_EN
    localparam int BAR_W  = H_PIX / 8;
    localparam int BAR_CW = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);
    localparam logic [BAR_CW-1:0] BAR_ONE  = BAR_CW'(1);

    logic              pat_q;
    logic [BAR_CW-1:0] bar_left, bar_left_n;   // pixels left in the current bar
    logic [2:0]        bar_idx, bar_idx_n;

    // A bar advances after the low byte of its last pixel; no x/BAR_W divide.
    always_comb begin
        bar_left_n = bar_left;
        bar_idx_n  = bar_idx;
        if (line_start) begin
            bar_left_n = BAR_LAST;
            bar_idx_n  = 3'd0;
        end else if (byte_step && phase) begin
            if (bar_left == '0) begin
                bar_left_n = BAR_LAST;
                bar_idx_n  = bar_idx + 3'd1;
            end else begin
                bar_left_n = bar_left - BAR_ONE;
            end
        end
    end

    always_comb begin
        pix_n = col_q;
        if (pat_q) begin
            case (bar_idx_n)
                3'd0:    pix_n = 16'hFFFF;
                3'd1:    pix_n = 16'hFFE0;
                3'd2:    pix_n = 16'h07FF;
                3'd3:    pix_n = 16'h07E0;
                3'd4:    pix_n = 16'hF81F;
                3'd5:    pix_n = 16'hF800;
                3'd6:    pix_n = 16'h001F;
                default: pix_n = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge in_reset) begin
        if (in_reset) begin
            pat_q    <= 1'b0;
            bar_left <= '0;
            bar_idx  <= 3'd0;
        end else begin
            if (sample) begin
                pat_q <= pattern;
            end
            bar_left <= bar_left_n;
            bar_idx  <= bar_idx_n;
        end
    end
`else
    logic unused_pattern;
    assign unused_pattern = pattern;
    assign pix_n          = col_q;
`endif

    always_ff @(posedge pclk or posedge in_reset) begin
        if (in_reset) begin
            state        <= ST_IDLE;
            cyc          <= '0;
            lines        <= '0;
            phase        <= 1'b0;
            col_q        <= 16'h0000;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            px_q         <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
        end else begin
            state        <= state_n;
            cyc          <= cyc_n;
            lines        <= lines_n;
            phase        <= phase_n;
            if (sample) begin
                col_q <= color;
            end
            vsync_q      <= (state_n == ST_VSYNC);
            href_q       <= (state_n == ST_ACTIVE);
            if (state_n == ST_ACTIVE) begin
                px_q <= phase_n ? pix_n[7:0] : pix_n[15:8];
            end else begin
                px_q <= 8'h00;
            end
            frame_done_q <= done_n;
            if (done_n) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign vid.vsync   = vsync_q;
    assign vid.href    = href_q;
    assign vid.px_data = px_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_tx.sv
module tb_ov7670_tx;

    localparam int H_PIX       = 16;
    localparam int V_LINES     = 6;
    localparam int H_BLANK     = 4;
    localparam int VSYNC_LINES = 3;
    localparam int V_BACK      = 2;
    localparam int V_FRONT     = 2;
    localparam int T_LINE      = 2*H_PIX + H_BLANK;                                  // 36
    localparam int ACT_START   = (VSYNC_LINES + V_BACK) * T_LINE;                    // 180
    localparam int FRAME       = (VSYNC_LINES + V_BACK + V_LINES + V_FRONT) * T_LINE; // 468
`ifdef OV7670_TX_TESTPAT_EN
    localparam bit BARS_ON = 1'b1;
`else
    localparam bit BARS_ON = 1'b0;
`endif

    logic        pclk     = 1'b0;
    logic        in_reset = 1'b1;
    logic        enable   = 1'b0;
    logic        pattern  = 1'b0;
    logic [15:0] color    = 16'h0000;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    ov7670_tx_if vid ();

    ov7670_tx #(
        .H_PIX       (H_PIX),
        .V_LINES     (V_LINES),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) dut (
        .pclk       (pclk),
        .in_reset   (in_reset),
        .enable     (enable),
        .pattern    (pattern),
        .color      (color),
        .vid        (vid),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 pclk = ~pclk;

    int cyc_cnt = 0;
    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input logic [15:0] col, input logic pat, input int x);
        logic [15:0] p;
        p = col;
        if (BARS_ON && pat) begin
            case (x / (H_PIX/8))
                0:       p = 16'hFFFF;
                1:       p = 16'hFFE0;
                2:       p = 16'h07FF;
                3:       p = 16'h07E0;
                4:       p = 16'hF81F;
                5:       p = 16'hF800;
                6:       p = 16'h001F;
                default: p = 16'h0000;
            endcase
        end
        return p;
    endfunction

    int          rises[$];
    logic [15:0] first_px;
    logic [15:0] last_px;

    // Waits for vsync to rise, then compares every cycle of one frame
    // against a position-based model. drop_at < 0 keeps enable high.
    task automatic run_frame(input logic [15:0] col, input logic pat, input int drop_at,
                             input int exp_cnt, input string tag);
        int n, errs, first_t, pulses, bytes, dones, cnt_at_done, a, c;
        logic exp_vs, exp_hr, exp_fd, prev_href;
        logic [7:0]  exp_px;
        logic [15:0] p;
        color   = col;
        pattern = pat;
        enable  = 1'b1;
        n = 0;
        while (vid.vsync !== 1'b1 && n < 4*FRAME) begin
            @(negedge pclk);
            n++;
        end
        if (vid.vsync !== 1'b1) begin
            chk({tag, " vsync_rise_timeout"}, 0, 1);
            return;
        end
        rises.push_back(cyc_cnt);
        errs = 0; first_t = -1; pulses = 0; bytes = 0; dones = 0; cnt_at_done = -1;
        prev_href = 1'b0; first_px = 16'h0; last_px = 16'h0;
        for (int t = 0; t < FRAME; t++) begin
            if (t == drop_at) enable = 1'b0;
            if (t == VSYNC_LINES*T_LINE + 3) begin
                color   = ~col;
                pattern = ~pat;
            end
            exp_vs = (t < VSYNC_LINES*T_LINE);
            exp_hr = 1'b0;
            exp_px = 8'h00;
            a = t - ACT_START;
            if (a >= 0 && a < V_LINES*T_LINE) begin
                c = a % T_LINE;
                if (c < 2*H_PIX) begin
                    exp_hr = 1'b1;
                    p      = exp_pix(col, pat, c/2);
                    exp_px = (c % 2 == 1) ? p[7:0] : p[15:8];
                end
            end
            exp_fd = (t == FRAME-1);
            if ({vid.vsync, vid.href, vid.px_data, frame_done} !== {exp_vs, exp_hr, exp_px, exp_fd}) begin
                if (errs == 0) first_t = t;
                errs++;
            end
            if (vid.href === 1'b1) begin
                if (bytes == 0) first_px[15:8] = vid.px_data;
                if (bytes == 1) first_px[7:0]  = vid.px_data;
                last_px = {last_px[7:0], vid.px_data};
                bytes++;
                if (!prev_href) pulses++;
            end
            prev_href = vid.href;
            if (frame_done === 1'b1) begin
                dones++;
                cnt_at_done = int'(frame_cnt);
            end
            @(negedge pclk);
        end
        chk($sformatf("%s cycle_errs(first t=%0d)", tag, first_t), errs, 0);
        chk({tag, " href_pulses"}, pulses, V_LINES);
        chk({tag, " byte_total"}, bytes, 2*H_PIX*V_LINES);
        chk({tag, " frame_done_pulses"}, dones, 1);
        chk({tag, " frame_cnt"}, cnt_at_done, exp_cnt);
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge pclk);
            if (vid.vsync !== 1'b0 || vid.href !== 1'b0) hi++;
        end
        chk({tag, " sync_high_cycles"}, hi, 0);
    endtask

    typedef struct {
        logic [15:0] color;
        logic        pat;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{16'hF800, 1'b0, 16'hF800, 16'hF800};
        vecs[1] = '{16'h07E0, 1'b0, 16'h07E0, 16'h07E0};
        vecs[2] = '{16'hA5C3, 1'b1, BARS_ON ? 16'hFFFF : 16'hA5C3, BARS_ON ? 16'h0000 : 16'hA5C3};
        vecs[3] = '{16'h001F, 1'b1, BARS_ON ? 16'hFFFF : 16'h001F, BARS_ON ? 16'h0000 : 16'h001F};
        vecs[4] = '{16'h3C5A, 1'b0, 16'h3C5A, 16'h3C5A};

        // reset and idle
        repeat (5) @(negedge pclk);
        chk("rst vsync", int'(vid.vsync), 0);
        chk("rst href", int'(vid.href), 0);
        chk("rst px_data", int'(vid.px_data), 0);
        chk("rst frame_done", int'(frame_done), 0);
        chk("rst frame_cnt", int'(frame_cnt), 0);
        in_reset = 1'b0;
        idle_check(1000, "idle");

        // single frames from IDLE, enable dropped right after vsync rises
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].color, vecs[i].pat, 1, i + 1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d first_px", i), int'(first_px), int'(vecs[i].exp_first));
            chk($sformatf("vec%0d last_px", i), int'(last_px), int'(vecs[i].exp_last));
        end
        idle_check(50, "post_vec");

        // continuous run of three frames
        rises.delete();
        run_frame(16'h1234, 1'b0, -1, 6, "cont0");
        run_frame(16'h4321, 1'b0, -1, 7, "cont1");
        run_frame(16'hBEEF, 1'b0, FRAME - 5, 8, "cont2");
        chk("cont rise_count", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("cont spacing01", rises[1] - rises[0], FRAME);
            chk("cont spacing12", rises[2] - rises[1], FRAME);
        end

        // enable dropped mid-frame, in the middle active line
        run_frame(16'hC0DE, 1'b0, ACT_START + (V_LINES/2)*T_LINE + 3, 9, "middis");
        idle_check(2*FRAME, "middis_idle");

        // reset in the middle of an active line
        color  = 16'hF800;
        enable = 1'b1;
        n = 0;
        while (vid.vsync !== 1'b1 && n < 4*FRAME) begin
            @(negedge pclk);
            n++;
        end
        chk("mrst vsync_seen", int'(vid.vsync), 1);
        repeat (ACT_START + 2*T_LINE + 4) @(negedge pclk);
        chk("mrst pre href", int'(vid.href), 1);
        chk("mrst pre px", int'(vid.px_data), 8'hF8);
        #2 in_reset = 1'b1;
        #1;
        chk("mrst href", int'(vid.href), 0);
        chk("mrst vsync", int'(vid.vsync), 0);
        chk("mrst px_data", int'(vid.px_data), 0);
        chk("mrst frame_cnt", int'(frame_cnt), 0);
        repeat (3) @(negedge pclk);
        in_reset = 1'b0;
        run_frame(16'hF800, 1'b0, 1, 1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
